// File: rtl/uart_rx.sv
// uart_rx : 8N1 UART receiver with an AXI-Stream master output.
//   Recovers bytes from an asynchronous serial line and holds each one in a
//   single-entry output register. There is no FIFO. Framing errors and
//   overruns are reported as one-cycle pulses.
// Ports:
//   m_axis_aclk     in   sole clock
//   m_axis_aresetn  in   async assert, active-low reset
//   rx_bit          in   serial line (async to clock, idles high)
//   m_axis_tvalid   out  byte available
//   m_axis_tdata    out  received byte (LSB first on the wire)
//   m_axis_tready   in   consumer ready
//   frame_error     out  1-cycle pulse: stop bit sampled low
//   overrun         out  1-cycle pulse: good byte arrived while tvalid held
module uart_rx #(
  parameter int CLOCK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE     = 115_200
) (
  input  logic       m_axis_aclk,
  input  logic       m_axis_aresetn,
  input  logic       rx_bit,
  output logic       m_axis_tvalid,
  output logic [7:0] m_axis_tdata,
  input  logic       m_axis_tready,
  output logic       frame_error,
  output logic       overrun
);

  localparam int UART_CYCLES = CLOCK_FREQ_HZ / BAUD_RATE;
  localparam int HALF_CYCLES = UART_CYCLES / 2;
  localparam int CW          = $clog2(UART_CYCLES);
  localparam logic [CW-1:0] C_FULL = CW'(UART_CYCLES - 1);
  localparam logic [CW-1:0] C_HALF = CW'(HALF_CYCLES - 1);

  generate
    if (UART_CYCLES < 4) begin : g_bad_baud
      $error("uart_rx: CLOCK_FREQ_HZ/BAUD_RATE must be >= 4");
    end
  endgenerate

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic [1:0]    r_sync;
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_deliver;
  logic          r_tvalid;
  logic [7:0]    r_tdata;
  logic          r_frame_error;
  logic          r_overrun;

  logic          w_rx_s;
  logic          w_tick;
  logic [2:0]    w_next_state;

  assign w_rx_s = r_sync[1];
  // Mid-bit point for DATA/STOP (counter runs a full bit period there)
  assign w_tick = (r_cnt == C_FULL);

  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;
  assign frame_error   = r_frame_error;
  assign overrun       = r_overrun;

  // Two-flop synchronizer; resets to the idle (high) line level
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) r_sync <= 2'b11;
    else                 r_sync <= {r_sync[0], rx_bit};
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (!w_rx_s) w_next_state = S_START;
      // Half-bit recheck rejects short glitches silently
      S_START: if (r_cnt == C_HALF) w_next_state = w_rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (w_tick && (r_bit_idx == 3'd7)) w_next_state = S_STOP;
      S_STOP:  if (w_tick) w_next_state = w_rx_s ? S_IDLE : S_BREAK;
      // Held-low line must return high before a new start is accepted
      S_BREAK: if (w_rx_s) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_next_state != r_state)
        r_cnt <= '0;
      else if (((r_state == S_DATA) || (r_state == S_STOP)) && w_tick)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_deliver     <= 1'b0;
      r_tvalid      <= 1'b0;
      r_tdata       <= '0;
      r_frame_error <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      if (r_state == S_START)
        r_bit_idx <= '0;
      else if ((r_state == S_DATA) && w_tick) begin
        r_shift   <= {w_rx_s, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 1'b1;
      end

      // Byte is handed to the output stage one cycle after the good stop sample
      r_deliver     <= (r_state == S_STOP) && w_tick && w_rx_s;
      r_frame_error <= (r_state == S_STOP) && w_tick && !w_rx_s;
      r_overrun     <= 1'b0;

      if (r_deliver) begin
        if (!r_tvalid || m_axis_tready) begin
          r_tdata  <= r_shift;
          r_tvalid <= 1'b1;
        end else begin
          // Consumer still holding the previous byte: drop the new one
          r_overrun <= 1'b1;
        end
      end else if (r_tvalid && m_axis_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx : directed self-checking bench for uart_rx at 10 clocks per bit.
module tb_uart_rx;

  localparam int UC   = 10;
  localparam int HALF = UC / 2;

  logic       clk;
  logic       rstn;
  logic       rx_bit;
  logic       tvalid;
  logic [7:0] tdata;
  logic       tready;
  logic       fe;
  logic       ovr;

  int n_cmp = 0;
  int n_err = 0;

  uart_rx #(.CLOCK_FREQ_HZ(100), .BAUD_RATE(10)) dut (
    .m_axis_aclk   (clk),
    .m_axis_aresetn(rstn),
    .rx_bit        (rx_bit),
    .m_axis_tvalid (tvalid),
    .m_axis_tdata  (tdata),
    .m_axis_tready (tready),
    .frame_error   (fe),
    .overrun       (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observer: records accepted beats, pulse-cycle counts and tvalid rise time
  int         cyc = 0;
  logic [7:0] beats[$];
  int         fe_cnt = 0;
  int         ovr_cnt = 0;
  int         rise_cyc = -1;
  logic       tv_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tvalid && tready) beats.push_back(tdata);
    if (fe) fe_cnt++;
    if (ovr) ovr_cnt++;
    if (tvalid && !tv_prev) rise_cyc = cyc;
    tv_prev = tvalid;
  end

  function automatic logic [7:0] beat_at(input int i);
    if (i < beats.size()) return beats[i];
    return 8'hxx;
  endfunction

  task automatic idle(input int n);
    rx_bit = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx_bit = v;
    repeat (UC) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [7:0] bb;
    bb = b;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(bb[i]);
    drive_bit(stop);
  endtask

  task automatic test_reset;
    rstn = 1'b0; rx_bit = 1'b1; tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if (tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b want 0", tvalid); end
    n_cmp++;
    if (tdata !== 8'h00) begin n_err++; $display("FAIL reset_tdata: got %h want 00", tdata); end
    n_cmp++;
    if (fe !== 1'b0) begin n_err++; $display("FAIL reset_frame_error: got %b want 0", fe); end
    n_cmp++;
    if (ovr !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", ovr); end
    n_cmp++;
    rstn = 1'b1;
    idle(5);
  endtask

  task automatic test_single;
    int b0, f0, o0, t0;
    b0 = beats.size(); f0 = fe_cnt; o0 = ovr_cnt;
    tready = 1'b1;
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    idle(20);
    if (beats.size() - b0 !== 1) begin n_err++; $display("FAIL single_count: got %0d want 1", beats.size() - b0); end
    n_cmp++;
    if (beat_at(b0) !== 8'hA5) begin n_err++; $display("FAIL single_data: got %h want a5", beat_at(b0)); end
    n_cmp++;
    // rx_bit set low one edge before the sync flop registers it
    if (rise_cyc - t0 !== 1 + 3 + HALF + 9 * UC) begin
      n_err++; $display("FAIL single_latency: got %0d want %0d", rise_cyc - t0, 1 + 3 + HALF + 9 * UC);
    end
    n_cmp++;
    if (fe_cnt - f0 !== 0) begin n_err++; $display("FAIL single_frame_error: got %0d want 0", fe_cnt - f0); end
    n_cmp++;
    if (ovr_cnt - o0 !== 0) begin n_err++; $display("FAIL single_overrun: got %0d want 0", ovr_cnt - o0); end
    n_cmp++;
    if (tvalid !== 1'b0) begin n_err++; $display("FAIL single_tvalid_drop: got %b want 0", tvalid); end
    n_cmp++;
  endtask

  task automatic test_back_to_back;
    int b0, f0;
    b0 = beats.size(); f0 = fe_cnt;
    tready = 1'b1;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(30);
    if (beats.size() - b0 !== 3) begin n_err++; $display("FAIL b2b_count: got %0d want 3", beats.size() - b0); end
    n_cmp++;
    if (beat_at(b0) !== 8'h00) begin n_err++; $display("FAIL b2b_beat0: got %h want 00", beat_at(b0)); end
    n_cmp++;
    if (beat_at(b0 + 1) !== 8'hFF) begin n_err++; $display("FAIL b2b_beat1: got %h want ff", beat_at(b0 + 1)); end
    n_cmp++;
    if (beat_at(b0 + 2) !== 8'h3C) begin n_err++; $display("FAIL b2b_beat2: got %h want 3c", beat_at(b0 + 2)); end
    n_cmp++;
    if (fe_cnt - f0 !== 0) begin n_err++; $display("FAIL b2b_frame_error: got %0d want 0", fe_cnt - f0); end
    n_cmp++;
  endtask

  // A low pulse shorter than half a bit is rejected at the START recheck
  task automatic test_glitch;
    int b0, f0, o0;
    b0 = beats.size(); f0 = fe_cnt; o0 = ovr_cnt;
    tready = 1'b1;
    rx_bit = 1'b0;
    repeat (HALF - 2) @(posedge clk);
    #1;
    idle(40);
    if (beats.size() - b0 !== 0) begin n_err++; $display("FAIL glitch_no_beat: got %0d want 0", beats.size() - b0); end
    n_cmp++;
    if (fe_cnt - f0 !== 0) begin n_err++; $display("FAIL glitch_frame_error: got %0d want 0", fe_cnt - f0); end
    n_cmp++;
    if (ovr_cnt - o0 !== 0) begin n_err++; $display("FAIL glitch_overrun: got %0d want 0", ovr_cnt - o0); end
    n_cmp++;
    // Receiver must be back in IDLE: a following clean frame decodes
    send_frame(8'h96, 1'b1);
    idle(20);
    if (beat_at(b0) !== 8'h96) begin n_err++; $display("FAIL glitch_next_frame: got %h want 96", beat_at(b0)); end
    n_cmp++;
  endtask

  task automatic test_frame_error;
    int b0, f0, o0;
    b0 = beats.size(); f0 = fe_cnt; o0 = ovr_cnt;
    tready = 1'b1;
    send_frame(8'h55, 1'b0);
    rx_bit = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    idle(20);
    if (fe_cnt - f0 !== 1) begin n_err++; $display("FAIL ferr_pulse: got %0d want 1", fe_cnt - f0); end
    n_cmp++;
    if (beats.size() - b0 !== 0) begin n_err++; $display("FAIL ferr_discard: got %0d want 0", beats.size() - b0); end
    n_cmp++;
    send_frame(8'h12, 1'b1);
    idle(20);
    if (beats.size() - b0 !== 1) begin n_err++; $display("FAIL ferr_recover_count: got %0d want 1", beats.size() - b0); end
    n_cmp++;
    if (beat_at(b0) !== 8'h12) begin n_err++; $display("FAIL ferr_recover_data: got %h want 12", beat_at(b0)); end
    n_cmp++;
    if (ovr_cnt - o0 !== 0) begin n_err++; $display("FAIL ferr_overrun: got %0d want 0", ovr_cnt - o0); end
    n_cmp++;
  endtask

  task automatic test_overrun;
    int b0, o0;
    b0 = beats.size(); o0 = ovr_cnt;
    tready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(20);
    if (tvalid !== 1'b1) begin n_err++; $display("FAIL ovr_tvalid_held: got %b want 1", tvalid); end
    n_cmp++;
    if (tdata !== 8'h11) begin n_err++; $display("FAIL ovr_tdata_held: got %h want 11", tdata); end
    n_cmp++;
    if (ovr_cnt - o0 !== 1) begin n_err++; $display("FAIL ovr_pulse: got %0d want 1", ovr_cnt - o0); end
    n_cmp++;
    tready = 1'b1;
    idle(5);
    if (beats.size() - b0 !== 1) begin n_err++; $display("FAIL ovr_drain_count: got %0d want 1", beats.size() - b0); end
    n_cmp++;
    if (beat_at(b0) !== 8'h11) begin n_err++; $display("FAIL ovr_drain_data: got %h want 11", beat_at(b0)); end
    n_cmp++;
    if (tvalid !== 1'b0) begin n_err++; $display("FAIL ovr_tvalid_drop: got %b want 0", tvalid); end
    n_cmp++;
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] b;
    int b0, f0, o0;
    tready = 1'b0;
    send_frame(8'h5A, 1'b1);
    idle(10);
    if (tvalid !== 1'b1 || tdata !== 8'h5A) begin
      n_err++; $display("FAIL midrst_preload: got %b/%h want 1/5a", tvalid, tdata);
    end
    n_cmp++;
    b = 8'h77;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(b[i]);
    rx_bit = b[3];
    repeat (HALF) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    if (tvalid !== 1'b0) begin n_err++; $display("FAIL midrst_tvalid: got %b want 0", tvalid); end
    n_cmp++;
    if (tdata !== 8'h00) begin n_err++; $display("FAIL midrst_tdata: got %h want 00", tdata); end
    n_cmp++;
    @(posedge clk);
    #1;
    rx_bit = 1'b1;
    rstn = 1'b1;
    idle(20);
    b0 = beats.size(); f0 = fe_cnt; o0 = ovr_cnt;
    tready = 1'b1;
    send_frame(8'h81, 1'b1);
    idle(20);
    if (beats.size() - b0 !== 1) begin n_err++; $display("FAIL midrst_next_count: got %0d want 1", beats.size() - b0); end
    n_cmp++;
    if (beat_at(b0) !== 8'h81) begin n_err++; $display("FAIL midrst_next_data: got %h want 81", beat_at(b0)); end
    n_cmp++;
    if (fe_cnt - f0 !== 0 || ovr_cnt - o0 !== 0) begin
      n_err++; $display("FAIL midrst_flags: got fe=%0d ovr=%0d want 0/0", fe_cnt - f0, ovr_cnt - o0);
    end
    n_cmp++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; rx_bit = 1'b1; tready = 1'b1;
    @(posedge clk);
    #1;
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_frame_error;
    test_overrun;
    test_reset_mid_frame;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
